// File: rtl/ahb_slave_mem_pkg.sv
// Shared types for the AHB slave memory slice.
// Holds the AHB transfer-type and response encodings, the hsize codes the
// slave understands, the data-phase FSM state type and a helper that turns
// a transfer size and byte offset into little-endian byte-lane enables.
package ahb_slave_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte lanes touched by a legal transfer. Only called for aligned
  // byte/halfword/word transfers, so the halfword case just picks a half.
  function automatic logic [3:0] lane_enables(input logic [2:0] size,
                                              input logic [1:0] offset);
    logic [3:0] lanes;
    lanes = 4'b1111;
    if (size == HSIZE_BYTE) begin
      lanes = 4'b0001 << offset;
    end else if (size == HSIZE_HALF) begin
      lanes = offset[1] ? 4'b1100 : 4'b0011;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_slv_sram.sv
// Single-port word-wide backing store for the AHB slave.
// Ports:
//   clk   - write clock
//   addr  - word index, shared by read and write
//   we    - per-byte write enables, bit n writes wdata[8n+7:8n]
//   wdata - write data
//   rdata - combinational read of the addressed word
// Contents are never reset.
module ahb_slv_sram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-granular synchronous write; lanes without an enable keep their data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave in front of a word-addressed SRAM.
// Ports:
//   hclk, hreset         - clock and synchronous active-high reset
//   hsel, hready, htrans - address-phase qualifiers
//   haddr, hwrite, hsize - address-phase control, latched on acceptance
//   hwdata               - write data, sampled in the final data-phase cycle
//   hrdata               - read data, nonzero only in a read's final cycle
//   hreadyout, hresp     - registered slave handshake and response
// Legal transfers stall for WAIT_STATES cycles; illegal ones (out of range,
// oversize or misaligned) get the two-cycle ERROR response and never touch
// memory.
module ahb_slave_mem
  import ahb_slave_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);

  state_e          state;
  hresp_e          resp_q;
  logic            pend_valid;
  logic            pend_write;
  logic [AW-1:0]   pend_index;
  logic [1:0]      pend_offset;
  logic [2:0]      pend_size;
  logic [3:0]      wait_cnt;

  logic            accept;
  logic            legal;
  logic            final_cycle;
  logic [3:0]      sram_we;
  logic [31:0]     sram_rdata;

  // A new transfer is taken only while we are ready ourselves, so address
  // phases presented during our own stall are ignored. Legality is judged
  // on the raw address-phase inputs so the FSM can branch straight to ERR1.
  always_comb begin
    accept = hsel && hready && hreadyout &&
             (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    legal  = 1'b1;
    if ({1'b0, haddr} >= ADDR_LIMIT) legal = 1'b0;
    if (hsize > HSIZE_WORD) legal = 1'b0;
    if (hsize == HSIZE_HALF && haddr[0]) legal = 1'b0;
    if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) legal = 1'b0;
  end

  // The final data-phase cycle of a legal transfer is the IDLE state with a
  // transfer still pending. Writes commit on that cycle's closing edge, which
  // is also the edge a pipelined read is accepted on, so the following read
  // sees the new bytes through the combinational SRAM read.
  assign final_cycle = (state == ST_IDLE) && pend_valid;
  assign sram_we     = (final_cycle && pend_write && !hreset)
                       ? lane_enables(pend_size, pend_offset) : 4'b0000;
  assign hrdata      = (final_cycle && !pend_write) ? sram_rdata : '0;
  assign hresp       = resp_q;

  // Data-phase FSM. IDLE and ERR2 both end a data phase and may accept the
  // next address phase; WAIT counts the stall down; ERR1 is the unready half
  // of the ERROR response. hreadyout/hresp are registered here so they are
  // set up one edge ahead of the cycle they describe.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= ST_IDLE;
      hreadyout   <= 1'b1;
      resp_q      <= HRESP_OKAY;
      pend_valid  <= 1'b0;
      pend_write  <= 1'b0;
      pend_index  <= '0;
      pend_offset <= '0;
      pend_size   <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          resp_q    <= HRESP_ERROR;
        end
        default: begin
          state      <= ST_IDLE;
          hreadyout  <= 1'b1;
          resp_q     <= HRESP_OKAY;
          pend_valid <= 1'b0;
          if (accept) begin
            pend_write  <= hwrite;
            pend_index  <= haddr[AW+1:2];
            pend_offset <= haddr[1:0];
            pend_size   <= hsize;
            if (!legal) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              resp_q    <= HRESP_ERROR;
            end else begin
              pend_valid <= 1'b1;
              if (WAIT_STATES != 0) begin
                state     <= ST_WAIT;
                hreadyout <= 1'b0;
                wait_cnt  <= WS;
              end
            end
          end
        end
      endcase
    end
  end

  ahb_slv_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (hclk),
    .addr  (pend_index),
    .we    (sram_we),
    .wdata (hwdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem. Instance A has no wait states, instance
// B has two; both share the bus signals and are picked with their own hsel.
// Inputs change 1ns after a rising edge and outputs are sampled there too.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hreadyout_a, hreadyout_b;
  logic        hresp_a, hresp_b;

  int n_compared = 0;
  int n_mismatch = 0;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_D = 3'd3;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut_a (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata_a), .hreadyout(hreadyout_a),
    .hresp(hresp_a)
  );

  ahb_slave_mem #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(2)) dut_b (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata_b), .hreadyout(hreadyout_b),
    .hresp(hresp_b)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic applyStimulus(input logic sa, input logic sb,
                               input logic [31:0] addr, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size);
    hsel_a = sa;
    hsel_b = sb;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 32'h0, T_IDLE, 1'b0, SZ_W);
  endtask

  task automatic checkOutput(input string tag, input bit inst_b,
                             input logic exp_rdy, input logic exp_resp,
                             input logic [31:0] exp_rdata);
    logic        obs_rdy;
    logic        obs_resp;
    logic [31:0] obs_rdata;
    obs_rdy   = inst_b ? hreadyout_b : hreadyout_a;
    obs_resp  = inst_b ? hresp_b     : hresp_a;
    obs_rdata = inst_b ? hrdata_b    : hrdata_a;
    n_compared++;
    assert (obs_rdy === exp_rdy) else begin
      n_mismatch++;
      $error("[TB] FAIL %s hreadyout: observed %b expected %b", tag, obs_rdy, exp_rdy);
    end
    n_compared++;
    assert (obs_resp === exp_resp) else begin
      n_mismatch++;
      $error("[TB] FAIL %s hresp: observed %b expected %b", tag, obs_resp, exp_resp);
    end
    n_compared++;
    assert (obs_rdata === exp_rdata) else begin
      n_mismatch++;
      $error("[TB] FAIL %s hrdata: observed 0x%08h expected 0x%08h", tag, obs_rdata, exp_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hready = 1'b1;
    hwdata = 32'h0;
    hreset = 1'b1;
    idleBus();
    tick();
    tick();
    checkOutput("reset_a", 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("reset_b", 1'b1, 1'b1, 1'b0, 32'h0);
    hreset = 1'b0;

    // A: write DEADBEEF to 0x10, read it back-to-back
    applyStimulus(1, 0, 32'h10, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'hDEADBEEF;
    checkOutput("a_wr_dp", 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h10, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("a_rd_dp", 0, 1, 0, 32'hDEADBEEF);
    idleBus();
    tick();
    checkOutput("a_rd_after", 0, 1, 0, 32'h0);

    // A: byte write into lane 3, then halfword write into the upper half
    applyStimulus(1, 0, 32'h10, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'h11223344;
    applyStimulus(1, 0, 32'h13, T_NSEQ, 1, SZ_B);
    tick();
    hwdata = 32'hAB000000;
    applyStimulus(1, 0, 32'h10, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("a_byte_wr", 0, 1, 0, 32'hAB223344);
    applyStimulus(1, 0, 32'h12, T_NSEQ, 1, SZ_H);
    tick();
    hwdata = 32'hCDEF0000;
    applyStimulus(1, 0, 32'h11, T_NSEQ, 0, SZ_B);
    tick();
    checkOutput("a_half_wr", 0, 1, 0, 32'hCDEF3344);
    idleBus();
    tick();

    // A: out-of-range read
    applyStimulus(1, 0, 32'h1000, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("a_oob_err1", 0, 0, 1, 32'h0);
    idleBus();
    tick();
    checkOutput("a_oob_err2", 0, 1, 1, 32'h0);
    tick();
    checkOutput("a_oob_end", 0, 1, 0, 32'h0);

    // A: misaligned word write must leave word 0 untouched
    applyStimulus(1, 0, 32'h00, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'h12345678;
    applyStimulus(1, 0, 32'h02, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'hFFFFFFFF;
    checkOutput("a_mis_err1", 0, 0, 1, 32'h0);
    idleBus();
    tick();
    checkOutput("a_mis_err2", 0, 1, 1, 32'h0);
    applyStimulus(1, 0, 32'h01, T_NSEQ, 1, SZ_H);
    tick();
    checkOutput("a_mish_err1", 0, 0, 1, 32'h0);
    idleBus();
    tick();
    applyStimulus(1, 0, 32'h00, T_NSEQ, 1, SZ_D);
    tick();
    checkOutput("a_size_err1", 0, 0, 1, 32'h0);
    idleBus();
    tick();
    checkOutput("a_size_err2", 0, 1, 1, 32'h0);
    applyStimulus(1, 0, 32'h00, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("a_err_mem", 0, 1, 0, 32'h12345678);

    // A: BUSY, IDLE and unselected writes are ignored
    applyStimulus(1, 0, 32'h00, T_BUSY, 1, SZ_W);
    tick();
    hwdata = 32'h0;
    checkOutput("a_busy", 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h00, T_IDLE, 1, SZ_W);
    tick();
    checkOutput("a_idle", 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h00, T_NSEQ, 1, SZ_W);
    tick();
    checkOutput("a_nosel", 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h00, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("a_busy_mem", 0, 1, 0, 32'h12345678);
    idleBus();
    tick();

    // B: two wait states on write then read of 0x20
    applyStimulus(0, 1, 32'h20, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'hA5A55A5A;
    idleBus();
    checkOutput("b_wr_w1", 1, 0, 0, 32'h0);
    tick();
    checkOutput("b_wr_w2", 1, 0, 0, 32'h0);
    tick();
    checkOutput("b_wr_fin", 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h20, T_NSEQ, 0, SZ_W);
    tick();
    checkOutput("b_rd_w1", 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h24, T_NSEQ, 1, SZ_W);
    tick();
    checkOutput("b_rd_w2", 1, 0, 0, 32'h0);
    idleBus();
    tick();
    checkOutput("b_rd_fin", 1, 1, 0, 32'hA5A55A5A);
    tick();
    checkOutput("b_no_latch", 1, 1, 0, 32'h0);

    // B: reset in the middle of a wait-stated write
    applyStimulus(0, 1, 32'h40, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'h0BADF00D;
    idleBus();
    tick();
    tick();
    tick();
    applyStimulus(0, 1, 32'h40, T_NSEQ, 1, SZ_W);
    tick();
    hwdata = 32'h00000055;
    idleBus();
    checkOutput("b_rst_wait", 1, 0, 0, 32'h0);
    hreset = 1'b1;
    tick();
    checkOutput("b_rst", 1, 1, 0, 32'h0);
    hreset = 1'b0;
    applyStimulus(0, 1, 32'h40, T_NSEQ, 0, SZ_W);
    tick();
    idleBus();
    tick();
    tick();
    checkOutput("b_rst_mem", 1, 1, 0, 32'h0BADF00D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
